run_sequencer: RTL

Batch sequencer for the three matrix-multiply engines: single-PE, 2×2 systolic and 3×3 systolic. On a `go` pulse it runs each engine selected in `mode_mask`, one at a time, lowest index first. For each engine it clears the engines, issues a start pulse, waits for that engine's done pulse or a timeout, and records the cycle count. It drives `display_selection` with the last engine that completed successfully, and sits between the top-level controls and the engine controllers.

---
 rtl/run_seq_pkg.sv | 33 +++
 rtl/pending_picker.sv | 22 ++
 rtl/run_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and constants for the matrix-engine batch sequencer.
//   state_e     : sequencer FSM states
//   ENG_*       : engine codes used on cur_eng / display_selection
//   eng_onehot  : engine code -> one-hot engine bit (0 for ENG_NONE)
package run_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StStart,
    StWait,
    StNext,
    StDone
  } state_e;

  localparam logic [1:0] ENG_NONE   = 2'd0;
  localparam logic [1:0] ENG_SINGLE = 2'd1;
  localparam logic [1:0] ENG_2BY2   = 2'd2;
  localparam logic [1:0] ENG_3BY3   = 2'd3;

  function automatic logic [2:0] eng_onehot(input logic [1:0] eng);
    logic [2:0] oh;
    oh = 3'b000;
    case (eng)
      ENG_SINGLE: oh = 3'b001;
      ENG_2BY2:   oh = 3'b010;
      ENG_3BY3:   oh = 3'b100;
      default:    oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/pending_picker.sv
// Lowest-set-bit priority encoder over the engine mask.
//   mask_i : engine mask (bit0 single, bit1 2x2, bit2 3x3)
//   eng_o  : engine code of the lowest set bit, ENG_NONE when mask is empty
module pending_picker
  import run_seq_pkg::*;
(
  input  logic [2:0] mask_i,
  output logic [1:0] eng_o
);

  always_comb begin
    eng_o = ENG_NONE;
    if (mask_i[0]) begin
      eng_o = ENG_SINGLE;
    end else if (mask_i[1]) begin
      eng_o = ENG_2BY2;
    end else if (mask_i[2]) begin
      eng_o = ENG_3BY3;
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Batch sequencer for the single-PE, 2x2 and 3x3 matrix-multiply engines.
// On go it runs each selected engine in turn (lowest index first): clear pulse,
// start pulse, then wait for that engine's done or a timeout, recording the
// WAIT-cycle count.
//   clk, rstb          : clock, synchronous active-low reset
//   go, abort          : batch request (IDLE only) / abandon batch (priority)
//   mode_mask          : engines to run, captured with go
//   eng_done           : per-engine done pulses
//   eng_start          : one-hot start pulse to the active engine
//   rst_engines        : clear pulse ahead of every start
//   busy, cur_eng      : not-IDLE flag, active engine code
//   display_selection  : last engine that completed by done
//   cycle_count        : WAIT-cycle count of the last completed run
//   batch_done         : end-of-batch pulse
//   timeout_err        : sticky timeout flag, cleared by an accepted go
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             go,
  input  logic             abort,
  input  logic [2:0]       mode_mask,
  input  logic [2:0]       eng_done,
  output logic [2:0]       eng_start,
  output logic             rst_engines,
  output logic             busy,
  output logic [1:0]       cur_eng,
  output logic [1:0]       display_selection,
  output logic [CNT_W-1:0] cycle_count,
  output logic             batch_done,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [2:0]       pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cur_eng_q, cur_eng_d;
  logic [1:0]       disp_q, disp_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             timeout_err_q, timeout_err_d;
  logic [2:0]       eng_start_q, eng_start_d;
  logic             rst_engines_q, rst_engines_d;
  logic             busy_q, busy_d;
  logic             batch_done_q, batch_done_d;

  logic [2:0]       pick_mask;
  logic [1:0]       pick_eng;
  logic [2:0]       active_oh;
  logic             done_hit;
  logic [CNT_W-1:0] cnt_inc;

  // In IDLE the first engine comes straight from the incoming mask; afterwards
  // from what is still pending.
  assign pick_mask = (state_q == StIdle) ? mode_mask : pending_q;

  pending_picker u_picker (
    .mask_i (pick_mask),
    .eng_o  (pick_eng)
  );

  // Only the active engine's done bit is ever looked at.
  assign active_oh = eng_onehot(cur_eng_q);
  assign done_hit  = |(eng_done & active_oh);
  assign cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    cnt_d         = cnt_q;
    cur_eng_d     = cur_eng_q;
    disp_d        = disp_q;
    cycle_count_d = cycle_count_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      StIdle: begin
        if (go && !abort) begin
          timeout_err_d = 1'b0;
          if (mode_mask != 3'b000) begin
            pending_d = mode_mask;
            cur_eng_d = pick_eng;
            state_d   = StClear;
          end else begin
            state_d = StDone;
          end
        end
      end
      StClear: state_d = StStart;
      StStart: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_inc;
        if (done_hit) begin
          cycle_count_d = cnt_inc;
          disp_d        = cur_eng_q;
          pending_d     = pending_q & ~active_oh;
          state_d       = StNext;
        end else if (cnt_inc == TimeoutVal) begin
          timeout_err_d = 1'b1;
          pending_d     = pending_q & ~active_oh;
          state_d       = StNext;
        end
      end
      StNext: begin
        cur_eng_d = pick_eng;
        state_d   = (pending_q != 3'b000) ? StClear : StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort overrides whatever the state logic decided, but leaves the result
    // registers as they were.
    if (abort && (state_q != StIdle)) begin
      state_d       = StIdle;
      cur_eng_d     = ENG_NONE;
      pending_d     = 3'b000;
      disp_d        = disp_q;
      cycle_count_d = cycle_count_q;
      timeout_err_d = timeout_err_q;
    end

    // Pulse outputs are registered copies of the next-state decode, so they
    // are high exactly while the FSM sits in the matching state.
    eng_start_d   = (state_d == StStart) ? eng_onehot(cur_eng_d) : 3'b000;
    rst_engines_d = (state_d == StClear);
    busy_d        = (state_d != StIdle);
    batch_done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q       <= StIdle;
      pending_q     <= 3'b000;
      cnt_q         <= '0;
      cur_eng_q     <= ENG_NONE;
      disp_q        <= ENG_NONE;
      cycle_count_q <= '0;
      timeout_err_q <= 1'b0;
      eng_start_q   <= 3'b000;
      rst_engines_q <= 1'b0;
      busy_q        <= 1'b0;
      batch_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      cnt_q         <= cnt_d;
      cur_eng_q     <= cur_eng_d;
      disp_q        <= disp_d;
      cycle_count_q <= cycle_count_d;
      timeout_err_q <= timeout_err_d;
      eng_start_q   <= eng_start_d;
      rst_engines_q <= rst_engines_d;
      busy_q        <= busy_d;
      batch_done_q  <= batch_done_d;
    end
  end

  assign eng_start         = eng_start_q;
  assign rst_engines       = rst_engines_q;
  assign busy              = busy_q;
  assign cur_eng           = cur_eng_q;
  assign display_selection = disp_q;
  assign cycle_count       = cycle_count_q;
  assign batch_done        = batch_done_q;
  assign timeout_err       = timeout_err_q;

endmodule
